alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FIRST_PRIO, default 0, meaning: requester favoured on the first contended grant after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on rising clk.
REQ-004 req0_valid  input  1  requester 0 operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  4  requester 0 ALU select code (defines.vh encodings).
REQ-007 req0_a / req0_b  input  32 each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same directions/widths/meanings for requester 1.
REQ-009 alu_in_a / alu_in_b  output  32 each  operands driven to the shared combinational ALU.
REQ-010 alu_select  output  4  op code driven to the shared ALU.
REQ-011 alu_result  input  32  ALU result, same-cycle combinational return.
REQ-012 rsp_valid  output  1  response register holds a result.
REQ-013 rsp_ready  input  1  consumer accepts response this cycle.
REQ-014 rsp_id  output  1  requester index owning the response.
REQ-015 rsp_result  output  32  registered result.
REQ-016 rsp_err  output  1  response came from an illegal op code.

Function
REQ-017 Accept slot open when rsp_valid==0 or (rsp_valid && rsp_ready); at most one request accepted per cycle.
REQ-018 Grant: only one valid -> that one; both valid -> requester != last_grant; no valid -> no grant; no grant when slot closed.
REQ-019 last_grant register updates to the granted index only on acceptance; reset value = ~FIRST_PRIO (so FIRST_PRIO wins first contention).
REQ-020 reqN_ready = 1 only for the granted requester in an open-slot cycle; combinational from valids, last_grant, rsp state; never both high.
REQ-021 alu_in_a/alu_in_b/alu_select = granted requester's operands/op same cycle; with no grant, drive 0/0/ADD encoding.
REQ-022 Legal ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; on illegal op with grant, alu_select = ADD encoding, and response captured with rsp_result=0, rsp_err=1.
REQ-023 On acceptance, at next rising clk: rsp_valid=1, rsp_id=grant index, rsp_result=alu_result (legal op), rsp_err=0 (legal op).
REQ-024 Latency: request accepted cycle N -> rsp_valid in cycle N+1; throughput 1 op/cycle while rsp_ready held high.
REQ-025 Response registers hold stable while rsp_valid && !rsp_ready (backpressure); no request accepted then.
REQ-026 Drain without new acceptance (rsp_valid && rsp_ready, no grant) -> rsp_valid=0 next cycle; rsp_result/rsp_id/rsp_err retain values.
REQ-027 Simultaneous drain and acceptance -> response registers overwritten with new result, rsp_valid stays 1.
REQ-028 Response state machine: EMPTY (rsp_valid=0) -> FULL on accept; FULL -> FULL on accept-with-drain or stall; FULL -> EMPTY on drain without accept.
REQ-029 Requester dropping valid before ready is legal; no state change results.

Reset
REQ-030 With rst=1 at a rising clk: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, last_grant=~FIRST_PRIO; reqN_ready=0 during rst=1.
REQ-031 Reset asserted while FULL discards the held response; no response emitted for it after reset release.
REQ-032 Request presented in same cycle as rst=1 not accepted.

Verification
REQ-033 Single: req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready=1 cycle N; cycle N+1 rsp_valid=1, rsp_id=0, rsp_result=12, rsp_err=0.
REQ-034 Contention (FIRST_PRIO=0): both valid continuously, ops SUB 10-3 (req0) and SRA 0x80000000>>4 (req1), rsp_ready=1 -> grants alternate 0,1,0,1; results 7 and 0xF8000000 alternate.
REQ-035 Backpressure: accept req1 XOR 0xFF^0x0F, hold rsp_ready=0 for 3 cycles with req0 valid -> rsp_result=0xF0 stable, req0_ready=0; rsp_ready=1 -> req0 accepted same cycle.
REQ-036 Illegal op: req0_op outside legal set, a=1 b=1 -> rsp_valid=1, rsp_result=0, rsp_err=1, alu_select=ADD during grant.
REQ-037 Reset mid-op: accept req1 SLTU 1<2, assert rst while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 next cycle, no stale response afterwards, next contention grants req0.
REQ-038 Back-to-back single requester: req0 SLL 1<<k for k=0..31, rsp_ready=1 -> 32 responses in 32 consecutive cycles, results 1<<k in order.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundles the request, shared-ALU and response signals of alu_arbiter.
// The slave modport is the arbiter's view; the master modport is its environment's view.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    logic [31:0] alu_in_a;
    logic [31:0] alu_in_b;
    logic [3:0]  alu_select;
    logic [31:0] alu_result;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_in_a, alu_in_b, alu_select,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_result, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_in_a, alu_in_b, alu_select,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_result, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a single registered response slot and ready/valid backpressure.
module alu_arbiter #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
            OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

    logic [0:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_err_q, rsp_err_d;

    logic        slot_open;
    logic        gnt_vld;
    logic        gnt_idx;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_legal;

    // The slot is free when empty or when the held response leaves this cycle.
    assign slot_open = !rst && ((state_q == ST_EMPTY) || bus.rsp_ready);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (slot_open) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_vld = 1'b1;
                gnt_idx = ~last_grant_q;
            end else if (bus.req0_valid) begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b0;
            end else if (bus.req1_valid) begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b1;
            end
        end
    end

    assign bus.req0_ready = gnt_vld && !gnt_idx;
    assign bus.req1_ready = gnt_vld &&  gnt_idx;

    assign sel_op    = gnt_idx ? bus.req1_op : bus.req0_op;
    assign sel_a     = gnt_idx ? bus.req1_a  : bus.req0_a;
    assign sel_b     = gnt_idx ? bus.req1_b  : bus.req0_b;
    assign sel_legal = op_legal(sel_op);

    // Idle and illegal-op cycles present a harmless ADD to the shared ALU.
    assign bus.alu_in_a   = gnt_vld ? sel_a : 32'd0;
    assign bus.alu_in_b   = gnt_vld ? sel_b : 32'd0;
    assign bus.alu_select = (gnt_vld && sel_legal) ? sel_op : OP_ADD;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        if (gnt_vld) begin
            state_d      = ST_FULL;
            last_grant_d = gnt_idx;
            rsp_id_d     = gnt_idx;
            rsp_result_d = sel_legal ? bus.alu_result : 32'd0;
            rsp_err_d    = !sel_legal;
        end else if ((state_q == ST_FULL) && bus.rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            last_grant_q <= ~FIRST_PRIO;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.rsp_valid  = (state_q == ST_FULL);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule
